lcd_frame_blend: RTL

- Downstream of the LCD video output stage, in the clk_vid domain.
- Consumes its pixel stream (ce_pix, hs, vs, hbl, vbl, r, g, b) and emulates DMG/GBC LCD persistence: each active pixel is averaged with the same pixel from the previous frame, held in an on-chip frame store.
- Output is the same stream with one ce_pix of latency, feeding the scaler/video mixer.

---
 rtl/lcd_frame_blend_if.sv | 42 ++++
 rtl/lcd_frame_blend.sv | 132 +++++++++++++
 2 files changed

// File: rtl/lcd_frame_blend_if.sv
// Pixel stream into and out of the LCD persistence blender, plus the blend enable.
// The weight select exists only when LCD_FRAME_BLEND_WEIGHT_EN is defined.
interface lcd_frame_blend_if;
  logic       enable;
  logic       ce_pix;
  logic       hs_in;
  logic       vs_in;
  logic       hbl_in;
  logic       vbl_in;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic       hs;
  logic       vs;
  logic       hbl;
  logic       vbl;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       blending;
`ifdef LCD_FRAME_BLEND_WEIGHT_EN
  logic       weight;

  modport master (
    output enable, ce_pix, hs_in, vs_in, hbl_in, vbl_in, r_in, g_in, b_in, weight,
    input  hs, vs, hbl, vbl, r, g, b, blending
  );
  modport slave (
    input  enable, ce_pix, hs_in, vs_in, hbl_in, vbl_in, r_in, g_in, b_in, weight,
    output hs, vs, hbl, vbl, r, g, b, blending
  );
`else
  modport master (
    output enable, ce_pix, hs_in, vs_in, hbl_in, vbl_in, r_in, g_in, b_in,
    input  hs, vs, hbl, vbl, r, g, b, blending
  );
  modport slave (
    input  enable, ce_pix, hs_in, vs_in, hbl_in, vbl_in, r_in, g_in, b_in,
    output hs, vs, hbl, vbl, r, g, b, blending
  );
`endif
endinterface

// File: rtl/lcd_frame_blend.sv
// LCD persistence emulation: each active pixel is averaged with the same pixel of the previous frame.
// Define LCD_FRAME_BLEND_WEIGHT_EN to add a weight input selecting a 75/25 (current/previous) mix.
module lcd_frame_blend #(
  parameter int H_PIX  = 160,
  parameter int V_PIX  = 144,
  parameter int ADDR_W = 15
) (
  input logic              clk_vid,
  input logic              reset,
  lcd_frame_blend_if.slave vid
);
  localparam int                N_PIX    = H_PIX * V_PIX;
  localparam logic [ADDR_W-1:0] ADDR_SAT = ADDR_W'(N_PIX);

  // state  | meaning
  // BYPASS | blend off, stream passes straight through
  // ARM    | enabled, waiting for a frame start before filling
  // FILL   | storing one whole frame, output unblended
  // BLEND  | store holds the previous frame, active pixels are mixed
  typedef enum logic [1:0] {BYPASS, ARM, FILL, BLEND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hs_q, vs_q, hbl_q, vbl_q;
  logic [23:0]       rgb_q, rgb_d;
  logic [23:0]       rd_q;
  logic [23:0]       store [N_PIX];

  logic              active, frame_start, addr_ok, wr_en, blend_pix, w_sel;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [7:0] mix(input logic [7:0] cur, input logic [7:0] prev,
                                     input logic w);
    if (w)
      return 8'((10'(cur) * 10'd3 + 10'(prev) + 10'd2) >> 2);
    return 8'((9'(cur) + 9'(prev) + 9'd1) >> 1);
  endfunction

  // vbl_q is the vblank seen on the previous strobe, so it doubles as the edge detector
  always_comb begin
    active      = vid.ce_pix & ~vid.hbl_in & ~vid.vbl_in;
    frame_start = vid.ce_pix & vbl_q & ~vid.vbl_in;
    addr_ok     = (addr_q != ADDR_SAT);
    rd_addr     = addr_ok ? addr_q : '0;
  end

  always_comb begin
    state_d = state_q;
    if (vid.ce_pix) begin
      if (!vid.enable) begin
        state_d = BYPASS;
      end else begin
        case (state_q)
          BYPASS:  state_d = ARM;
          ARM:     if (frame_start) state_d = FILL;
          FILL:    if (frame_start) state_d = BLEND;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Decisions use the next state so the frame-start pixel and an enable drop act immediately
  always_comb begin
    wr_en     = active & addr_ok & ((state_d == FILL) | (state_d == BLEND));
    blend_pix = active & addr_ok & (state_d == BLEND);
    addr_d    = addr_q;
    if (vid.ce_pix && vid.vbl_in)
      addr_d = '0;
    else if (active && addr_ok)
      addr_d = addr_q + 1'b1;
    rgb_d = {vid.r_in, vid.g_in, vid.b_in};
    if (blend_pix)
      rgb_d = {mix(vid.r_in, rd_q[23:16], w_sel),
               mix(vid.g_in, rd_q[15:8],  w_sel),
               mix(vid.b_in, rd_q[7:0],   w_sel)};
  end

`ifdef LCD_FRAME_BLEND_WEIGHT_EN
  logic weight_q;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset)
      weight_q <= 1'b0;
    else if (active)
      weight_q <= vid.weight;
  end

  assign w_sel = weight_q;
`else
  assign w_sel = 1'b0;
`endif

  // Raw input is stored, never the blended result
  always_ff @(posedge clk_vid) begin
    if (wr_en)
      store[addr_q] <= {vid.r_in, vid.g_in, vid.b_in};
    rd_q <= store[rd_addr];
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state_q <= BYPASS;
      addr_q  <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hbl_q   <= 1'b1;
      vbl_q   <= 1'b1;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (vid.ce_pix) begin
        hs_q  <= vid.hs_in;
        vs_q  <= vid.vs_in;
        hbl_q <= vid.hbl_in;
        vbl_q <= vid.vbl_in;
        rgb_q <= rgb_d;
      end
    end
  end

  assign vid.hs       = hs_q;
  assign vid.vs       = vs_q;
  assign vid.hbl      = hbl_q;
  assign vid.vbl      = vbl_q;
  assign vid.r        = rgb_q[23:16];
  assign vid.g        = rgb_q[15:8];
  assign vid.b        = rgb_q[7:0];
  assign vid.blending = (state_q == BLEND);

endmodule
